// File: rtl/calc_entry_seq.sv
// Operand/op entry sequencer for the 4-bit calculator front end.
// Captures A, Op, B on ENTER presses and strobes calc_go when complete.
module calc_entry_seq #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned OP_W    = 2,
    parameter int unsigned MAX_VAL = 9,
    parameter logic [OP_W-1:0] DIV_OP = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enter,
    input  logic              clear,
    output logic [DATA_W-1:0] save_1,
    output logic [DATA_W-1:0] save_2,
    output logic [OP_W-1:0]   Op,
    output logic [1:0]        display_state,
    output logic              calc_go,
    output logic              err
);

    localparam logic [1:0] S_A    = 2'b00;
    localparam logic [1:0] S_OP   = 2'b01;
    localparam logic [1:0] S_B    = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VAL);

    logic              enter_q;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] s1_q, s1_d;
    logic [DATA_W-1:0] s2_q, s2_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              go_q, go_d;
    logic              err_q, err_d;
    logic              press;
    logic              bad_b;

    assign press = enter & ~enter_q;
    assign bad_b = (data_in > MAX_V) ||
                   ((op_q == DIV_OP) && (data_in == '0));

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        op_d    = op_q;
        err_d   = err_q;
        go_d    = 1'b0;
        if (clear) begin
            state_d = S_A;
            s1_d    = '0;
            s2_d    = '0;
            op_d    = '0;
            err_d   = 1'b0;
        end else if (press) begin
            unique case (state_q)
                S_A: begin
                    if (data_in > MAX_V) begin
                        err_d = 1'b1;
                    end else begin
                        s1_d    = data_in;
                        err_d   = 1'b0;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    op_d    = data_in[OP_W-1:0];
                    err_d   = 1'b0;
                    state_d = S_B;
                end
                S_B: begin
                    if (bad_b) begin
                        err_d = 1'b1;
                    end else begin
                        s2_d    = data_in;
                        err_d   = 1'b0;
                        go_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // Press on the result screen starts a fresh expression.
                    s1_d    = '0;
                    s2_d    = '0;
                    op_d    = '0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enter_q <= 1'b1;
            state_q <= S_A;
            s1_q    <= '0;
            s2_q    <= '0;
            op_q    <= '0;
            go_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            enter_q <= enter;
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            op_q    <= op_d;
            go_q    <= go_d;
            err_q   <= err_d;
        end
    end

    assign save_1        = s1_q;
    assign save_2        = s2_q;
    assign Op            = op_q;
    assign display_state = state_q;
    assign calc_go       = go_q;
    assign err           = err_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Bench for calc_entry_seq: directed plan scenarios then random
// stimulus, all checked against an expression-entry model.
module tb_calc_entry_seq;

    logic       clk = 1'b0;
    logic       rst, enter, clear;
    logic [3:0] data_in;
    logic [3:0] save_1, save_2;
    logic [1:0] Op, display_state;
    logic       calc_go, err;

    int total = 0;
    int bad   = 0;

    // Model: which entry comes next (0=A,1=Op,2=B,3=result)
    int m_step, m_a, m_b, m_op, m_go, m_err, m_prev;

    calc_entry_seq dut (
        .clk(clk), .rst(rst), .data_in(data_in), .enter(enter),
        .clear(clear), .save_1(save_1), .save_2(save_2), .Op(Op),
        .display_state(display_state), .calc_go(calc_go), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(bit r, bit c, bit e, int d);
        bit pr;
        pr = e && (m_prev == 0);
        m_go = 0;
        if (r) begin
            m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0;
            m_prev = 1;
            return;
        end
        m_prev = e;
        if (c) begin
            m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0;
        end else if (pr) begin
            if (m_step == 0) begin
                if (d > 9) m_err = 1;
                else begin m_a = d; m_err = 0; m_step = 1; end
            end else if (m_step == 1) begin
                m_op = d % 4; m_err = 0; m_step = 2;
            end else if (m_step == 2) begin
                if (d > 9 || (m_op == 3 && d == 0)) m_err = 1;
                else begin
                    m_b = d; m_err = 0; m_step = 3; m_go = 1;
                end
            end else begin
                m_a = 0; m_b = 0; m_op = 0; m_step = 0;
            end
        end
    endtask

    task automatic cyc(bit r, bit c, bit e, int d);
        rst = r; clear = c; enter = e; data_in = 4'(d);
        @(posedge clk);
        model(r, c, e, d);
        #1;
        chk("state", 32'(display_state), 32'(m_step));
        chk("save_1", 32'(save_1), 32'(m_a));
        chk("save_2", 32'(save_2), 32'(m_b));
        chk("Op", 32'(Op), 32'(m_op));
        chk("calc_go", 32'(calc_go), 32'(m_go));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic press(int d);
        cyc(0, 0, 1, d);
        cyc(0, 0, 0, d);
    endtask

    initial begin
        m_step = 0; m_a = 0; m_b = 0; m_op = 0;
        m_go = 0; m_err = 0; m_prev = 1;
        rst = 1; clear = 0; enter = 1; data_in = 4'd1;
        // Reset with ENTER held through and after release of rst
        cyc(1, 0, 1, 1);
        cyc(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
        chk("rst_hold_state", 32'(display_state), 32'd0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        chk("rst_then_press", 32'(save_1), 32'd1);
        cyc(0, 1, 0, 0);
        // Full sequence 3, op 01, 7
        press(3);
        press(1);
        press(7);
        chk("seq_s1", 32'(save_1), 32'd3);
        chk("seq_s2", 32'(save_2), 32'd7);
        press(0);
        // Out of range then valid
        press(12);
        chk("oor_err", 32'(err), 32'd1);
        press(5);
        // Divide by zero
        press(3);
        press(0);
        chk("dz_err", 32'(err), 32'd1);
        press(4);
        press(9);
        // Held enter in S_A
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 2);
        chk("hold_state", 32'(display_state), 32'd1);
        cyc(0, 0, 0, 2);
        // Clear with press in S_B
        press(2);
        cyc(0, 1, 1, 5);
        chk("clr_state", 32'(display_state), 32'd0);
        cyc(0, 0, 0, 5);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, c, e;
            int d;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            cyc(r, c, e, d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_entry_seq.md
Name: calc_entry_seq

Overview:
- Front-end input sequencer for the 4-bit calculator.
- Captures operand 1, the operation code and operand 2 from the switch bank on successive ENTER presses.
- Drives the stored values plus the display_state selector consumed by the display multiplexer.
- Validates entries and issues a one-cycle compute strobe once a full expression is stored.

Parameters:
- DATA_W, 4: operand width in bits.
- OP_W, 2: operation code width in bits.
- MAX_VAL, 9: largest accepted operand value (BCD digit); larger values are rejected.
- DIV_OP, 2'b11: Op code meaning divide; used for the divide-by-zero check.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  switch value; sampled only on an accepted ENTER press.
- enter  input  1  ENTER button level, already debounced and synchronous to clk.
- clear  input  1  synchronous abort; returns to operand-1 entry.
- save_1  output  DATA_W  stored operand 1.
- save_2  output  DATA_W  stored operand 2.
- Op  output  OP_W  stored operation code.
- display_state  output  2  display selector: 00 = operand 1, 01 = Op, 10 = operand 2, 11 = result/idle.
- calc_go  output  1  single-cycle strobe; expression complete.
- err  output  1  sticky entry-error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - save_1, save_2, Op, calc_go and err all go to 0.
  - display_state goes to 00.
  - enter_q goes to 1, so an ENTER already held through reset does not register as a press.
- Press detection: press = enter & ~enter_q, where enter_q is enter registered every cycle.
  - One press per rising edge of enter.
  - Holding enter produces no further presses.
- Priority, highest first: rst > clear > press.
- clear at a clock edge:
  - display_state goes to 00.
  - save_1, save_2, Op and err go to 0; calc_go goes to 0.
  - A press in the same cycle is discarded.
- State machine (the state is display_state itself, fully registered):
  - S_A (00): press with data_in <= MAX_VAL → save_1 <= data_in, err <= 0, go to S_OP. Press with data_in > MAX_VAL → err <= 1, stay, save_1 unchanged.
  - S_OP (01): press → Op <= data_in[OP_W-1:0], err <= 0, go to S_B. Upper bits are ignored; there is no reject path.
  - S_B (10): press with data_in > MAX_VAL, or with Op == DIV_OP and data_in == 0 → err <= 1, stay, save_2 unchanged. Any other press → save_2 <= data_in, err <= 0, go to S_DONE.
  - S_DONE (11): save registers are held. Press → save_1, save_2 and Op go to 0, go to S_A. That press's data_in is not captured.
- calc_go:
  - Asserts for exactly the one cycle in which display_state first reads 11, i.e. registered together with the S_B → S_DONE transition.
  - Deasserted in every other cycle.
- err:
  - Changes only on a rejected press (set to 1), an accepted press (cleared to 0), clear, or rst.
  - Otherwise holds.
- Latency: outputs update on the clock edge that samples the press; no additional pipeline stages.
- Stability: no output changes in cycles without press, clear or rst, apart from calc_go returning to 0.
- Width rules: comparisons are unsigned over DATA_W; no truncation of operands.

Test Plan:
1. Full sequence, one-cycle pulses on enter: data 3 → Op 01 → data 7. Required: display_state 00→01→10→11; save_1=3, Op=01, save_2=7; calc_go high for exactly one cycle; err=0 throughout.
2. Out-of-range operand: data_in=12 pressed in S_A. Required: err=1, display_state stays 00, save_1=0. Then data_in=5 pressed. Required: err=0, save_1=5, display_state=01.
3. Divide by zero: Op=11 stored, then data 0 pressed in S_B. Required: err=1, display_state stays 10. Then data 4 pressed. Required: save_2=4, display_state=11, calc_go pulses once.
4. Held ENTER: enter high for 10 cycles in S_A with data 2. Required: exactly one capture, display_state=01, no advance to 10.
5. Clear mid-operation: clear and enter asserted together in S_B. Required: next cycle display_state=00; save_1=save_2=Op=0; err=0; no capture.
6. Reset: enter held high through rst and after its release. Required: no press detected, all outputs 0. A later release-then-press of enter with data 1 gives save_1=1.
